// File: rtl/baud_pkg.sv
// Shared widths and standard divisor settings for the UART timing generator.
package baud_pkg;

  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;
  localparam int OVERSAMPLE_DEF = 16;

  // Index width for an oversample count; OVERSAMPLE is a power of two >= 4.
  function automatic int os_idx_w(input int os);
    return $clog2(os);
  endfunction

  localparam int OS_IDX_W_DEF = os_idx_w(OVERSAMPLE_DEF);

  // 12 MHz system clock, 16x oversample: div + frac/16 cycles per os tick.
  localparam int BAUD9600_DIV    = 78;  // 78.125
  localparam int BAUD9600_FRAC   = 2;
  localparam int BAUD19200_DIV   = 39;  // 39.0625
  localparam int BAUD19200_FRAC  = 1;
  localparam int BAUD115200_DIV  = 6;   // 6.5 (target 6.51)
  localparam int BAUD115200_FRAC = 8;

endpackage

// File: rtl/baud_gen_if.sv
// Divisor configuration handshake: source offers div/frac with valid, sink accepts with ready.
interface baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              valid;
  logic              ready;
  logic [DIV_W-1:0]  div;
  logic [FRAC_W-1:0] frac;

  modport master (output valid, output div, output frac, input ready);
  modport slave  (input valid, input div, input frac, output ready);
endinterface

// File: rtl/frac_divider.sv
// Fractional cycle divider: emits a raw strobe every div or div+1 enabled cycles,
// with the +1 interval chosen by the carry of a fractional accumulator.
module frac_divider #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_stb
);
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  div_eff, last_cnt;

  // Divisors below 2 cannot produce distinct strobes; clamp to 2.
  assign div_eff  = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;
  assign last_cnt = carry_q ? div_eff : div_eff - DIV_W'(1);
  assign o_stb    = i_en && (cnt_q == last_cnt);

  // Count enabled cycles; at interval end wrap and accumulate the fraction.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (i_clr) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (i_en) begin
      if (cnt_q == last_cnt) begin
        cnt_d            = '0;
        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, i_frac};
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: rtl/baud_gen.sv
// UART timing generator: oversample/baud/mid-bit strobes, legacy baud square
// wave, and a divisor slot that switches rate only on a bit boundary.
module baud_gen
  import baud_pkg::*;
#(
  parameter int                DIV_W      = DIV_W_DEF,
  parameter int                FRAC_W     = FRAC_W_DEF,
  parameter int                OVERSAMPLE = OVERSAMPLE_DEF,
  parameter logic [DIV_W-1:0]  RST_DIV    = DIV_W'(BAUD9600_DIV),
  parameter logic [FRAC_W-1:0] RST_FRAC   = FRAC_W'(BAUD9600_FRAC),
  localparam int               OS_IDX_W   = os_idx_w(OVERSAMPLE)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  baud_gen_if.slave           cfg,
  input  logic                i_sync,
  output logic                o_os_tick,
  output logic                o_baud_tick,
  output logic                o_mid_tick,
  output logic [OS_IDX_W-1:0] o_os_idx,
  output logic                o_clk
);
  localparam logic [OS_IDX_W-1:0] MID_IDX = OS_IDX_W'(OVERSAMPLE / 2);

  logic                os_tick_q, os_tick_d, baud_tick_q, baud_tick_d, mid_tick_q, mid_tick_d;
  logic [OS_IDX_W-1:0] os_idx_q, os_idx_d, idx_inc;
  logic                clk_q, clk_d;
  logic                pend_q, pend_d;
  logic [DIV_W-1:0]    pend_div_q, pend_div_d, act_div_q, act_div_d;
  logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d, act_frac_q, act_frac_d;
  logic                stb, apply, clr;

  frac_divider #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_div (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en && !i_sync),
    .i_clr  (clr),
    .i_div  (act_div_q),
    .i_frac (act_frac_q),
    .o_stb  (stb)
  );

  assign idx_inc   = os_idx_q + OS_IDX_W'(1);
  assign cfg.ready = !pend_q;

  // Tick decode, bit phase and config slot; a pending rate lands on a bit
  // boundary (baud tick), while idle (i_en low), or on sync.
  always_comb begin
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    mid_tick_d  = 1'b0;
    os_idx_d    = os_idx_q;
    clk_d       = clk_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_frac_d = pend_frac_q;
    act_div_d   = act_div_q;
    act_frac_d  = act_frac_q;
    apply       = 1'b0;
    if (i_sync) begin
      os_idx_d = '0;
      clk_d    = 1'b0;
      apply    = pend_q;
    end else if (i_en) begin
      if (stb) begin
        os_tick_d   = 1'b1;
        os_idx_d    = idx_inc;
        baud_tick_d = (idx_inc == '0);
        mid_tick_d  = (idx_inc == MID_IDX);
        if (baud_tick_d || mid_tick_d) clk_d = !clk_q;
        if (baud_tick_d && pend_q) begin
          apply = 1'b1;
          clk_d = 1'b0;
        end
      end
    end else if (pend_q) begin
      apply    = 1'b1;
      os_idx_d = '0;
      clk_d    = 1'b0;
    end
    if (apply) begin
      act_div_d  = pend_div_q;
      act_frac_d = pend_frac_q;
      pend_d     = 1'b0;
    end
    if (cfg.valid && !pend_q) begin
      pend_d      = 1'b1;
      pend_div_d  = cfg.div;
      pend_frac_d = cfg.frac;
    end
  end

  assign clr = i_sync || apply;

  // State register; reset restores the power-on rate and drops any pending config.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      mid_tick_q  <= 1'b0;
      os_idx_q    <= '0;
      clk_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_frac_q <= '0;
      act_div_q   <= RST_DIV;
      act_frac_q  <= RST_FRAC;
    end else begin
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      mid_tick_q  <= mid_tick_d;
      os_idx_q    <= os_idx_d;
      clk_q       <= clk_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_frac_q <= pend_frac_d;
      act_div_q   <= act_div_d;
      act_frac_q  <= act_frac_d;
    end
  end

  assign o_os_tick   = os_tick_q;
  assign o_baud_tick = baud_tick_q;
  assign o_mid_tick  = mid_tick_q;
  assign o_os_idx    = os_idx_q;
  assign o_clk       = clk_q;
endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: vector table plus hand-written timing sequences.
module tb_baud_gen;
  import baud_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic os_tick, baud_tick, mid_tick, o_clk;
  logic [OS_IDX_W_DEF-1:0] os_idx;
  int checks = 0, failures = 0;

  baud_gen_if #(.DIV_W(16), .FRAC_W(4)) cfg_if ();

  baud_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .cfg(cfg_if), .i_sync(sync),
    .o_os_tick(os_tick), .o_baud_tick(baud_tick), .o_mid_tick(mid_tick),
    .o_os_idx(os_idx), .o_clk(o_clk)
  );

  always #5 clk = ~clk;

  typedef struct { logic en; int os; int idx; } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a divisor while idle; it is latched on the first edge and applied on the next.
  task automatic do_cfg(input int d, input int f);
    en = 1'b0;
    cfg_if.valid = 1'b1;
    cfg_if.div   = 16'(d);
    cfg_if.frac  = 4'(f);
    step();
    chk("cfg_ready_low", int'(cfg_if.ready), 0);
    cfg_if.valid = 1'b0;
    step();
    chk("cfg_ready_high", int'(cfg_if.ready), 1);
  endtask

  initial begin
    int e_os, e_baud, e_mid, e_idx, e_clk, cnt, b1, b2, w, bo, r43, r44, first, nb, tk, errs;
    int got[$];
    int expq[$];

    // div=1 (clamped to 2): tick every 2 enabled cycles, 7-cycle freeze in the middle.
    tbl[0]  = '{1'b1, 0, 0};
    tbl[1]  = '{1'b1, 1, 1};
    tbl[2]  = '{1'b1, 0, 1};
    for (int i = 3; i <= 9; i++) tbl[i] = '{1'b0, 0, 1};
    tbl[10] = '{1'b1, 1, 2};
    tbl[11] = '{1'b1, 0, 2};
    tbl[12] = '{1'b1, 1, 3};

    cfg_if.valid = 1'b0;
    cfg_if.div   = '0;
    cfg_if.frac  = '0;
    step();
    step();
    chk("rst_os_tick", int'(os_tick), 0);
    chk("rst_baud_tick", int'(baud_tick), 0);
    chk("rst_mid_tick", int'(mid_tick), 0);
    chk("rst_os_idx", int'(os_idx), 0);
    chk("rst_clk", int'(o_clk), 0);
    chk("rst_cfg_ready", int'(cfg_if.ready), 1);
    rst_n = 1'b1;

    // div=4 frac=0: os every 4, baud every 64, mid 32 after baud, o_clk 32/32.
    do_cfg(4, 0);
    en = 1'b1;
    e_os = 0; e_baud = 0; e_mid = 0; e_idx = 0; e_clk = 0;
    for (int n = 1; n <= 140; n++) begin
      step();
      if (int'(os_tick)   != int'(n % 4 == 0))   e_os++;
      if (int'(baud_tick) != int'(n % 64 == 0))  e_baud++;
      if (int'(mid_tick)  != int'(n % 64 == 32)) e_mid++;
      if (int'(os_idx)    != (n / 4) % 16)       e_idx++;
      if (int'(o_clk)     != int'(n % 64 >= 32)) e_clk++;
    end
    chk("div4_os_errs", e_os, 0);
    chk("div4_baud_errs", e_baud, 0);
    chk("div4_mid_errs", e_mid, 0);
    chk("div4_idx_errs", e_idx, 0);
    chk("div4_clk_errs", e_clk, 0);

    // div=4 frac=0.5: intervals 4,4,5,4,5..; 9 ticks in 40 cycles; baud period 72.
    do_cfg(4, 8);
    en = 1'b1;
    cnt = 0; b1 = -1; b2 = -1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (os_tick && n <= 40) cnt++;
      if (baud_tick) begin
        if (b1 < 0) b1 = n;
        else if (b2 < 0) b2 = n;
      end
    end
    chk("frac_ticks_40", cnt, 9);
    chk("frac_first_baud", b1, 71);
    chk("frac_baud_period", b2 - b1, 72);

    // Mid-bit reconfig to div=10: old rate runs to the baud tick, then 10-cycle spacing.
    do_cfg(4, 0);
    en = 1'b1;
    w = 0;
    while (!(os_tick && os_idx == 4'd5) && w < 400) begin
      step();
      w++;
    end
    chk("reconf_find_idx5", int'(os_tick && os_idx == 4'd5), 1);
    cfg_if.valid = 1'b1;
    cfg_if.div   = 16'd10;
    cfg_if.frac  = 4'd0;
    step();
    chk("reconf_ready_low", int'(cfg_if.ready), 0);
    cfg_if.valid = 1'b0;
    bo = -1; r43 = -1; r44 = -1;
    for (int off = 2; off <= 70; off++) begin
      step();
      if (os_tick) got.push_back(off);
      if (baud_tick && bo < 0) bo = off;
      if (off == 43) r43 = int'(cfg_if.ready);
      if (off == 44) r44 = int'(cfg_if.ready);
    end
    for (int k = 1; k <= 11; k++) expq.push_back(4 * k);
    expq.push_back(54);
    expq.push_back(64);
    errs = 0;
    for (int i = 0; i < expq.size(); i++)
      if (i >= got.size() || got[i] != expq[i]) errs++;
    chk("reconf_tick_count", got.size(), expq.size());
    chk("reconf_tick_pos_errs", errs, 0);
    chk("reconf_baud_offset", bo, 44);
    chk("reconf_ready_before", r43, 0);
    chk("reconf_ready_after", r44, 1);

    // Sync two cycles before an expected tick: tick suppressed, restart from phase 0.
    w = 0;
    while (!os_tick && w < 50) begin
      step();
      w++;
    end
    chk("sync_find_tick", int'(os_tick), 1);
    for (int k = 1; k <= 7; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_no_tick", int'(os_tick), 0);
    chk("sync_idx_clear", int'(os_idx), 0);
    chk("sync_clk_clear", int'(o_clk), 0);
    tk = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (os_tick) tk++;
    end
    chk("sync_gap_ticks", tk, 0);
    step();
    chk("sync_next_tick", int'(os_tick), 1);
    chk("sync_next_idx", int'(os_idx), 1);
    chk("sync_next_clk", int'(o_clk), 0);

    // Reset with a config pending: pending dropped, 9600-baud defaults restored.
    cfg_if.valid = 1'b1;
    cfg_if.div   = 16'd3;
    step();
    cfg_if.valid = 1'b0;
    chk("rst_pend_held", int'(cfg_if.ready), 0);
    rst_n = 1'b0;
    step();
    step();
    chk("rst_pend_dropped", int'(cfg_if.ready), 1);
    chk("rst2_idx", int'(os_idx), 0);
    rst_n = 1'b1;
    en = 1'b1;
    cnt = 0; nb = 0; first = -1;
    for (int n = 1; n <= 30000; n++) begin
      step();
      if (os_tick) begin
        cnt++;
        if (first < 0) first = n;
      end
      if (baud_tick) nb++;
    end
    chk("dflt_first_tick", first, BAUD9600_DIV);
    chk_rng("dflt_os_ticks", cnt, 383, 385);
    chk_rng("dflt_baud_ticks", nb, 23, 25);

    // div=1 clamp with enable freeze, from the vector table.
    do_cfg(1, 0);
    foreach (tbl[i]) begin
      en = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_os", i), int'(os_tick), tbl[i].os);
      chk($sformatf("tbl%0d_idx", i), int'(os_idx), tbl[i].idx);
    end

    // div=0 also clamps to 2.
    do_cfg(0, 0);
    en = 1'b1;
    cnt = 0; first = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (os_tick) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    chk("div0_first", first, 2);
    chk("div0_ticks", cnt, 10);

    // 115200 setting (6.5): intervals 6,6,7,6,7..; 40 ticks in 260 cycles.
    do_cfg(BAUD115200_DIV, BAUD115200_FRAC);
    en = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 260; n++) begin
      step();
      if (os_tick) cnt++;
    end
    chk("b115200_ticks", cnt, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
